alu_result_stage: RTL and testbench

//  Registered output stage sitting directly downstream of the ALU bitwise/arith units (AND/OR/ADD/SUB/shift).

---
 rtl/alu_result_stage.sv | 127 ++++++++++++
 tb/tb_alu_result_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered ALU result buffer: a DEPTH-entry circular FIFO with per-entry zero/sign flags
// and a saturating overflow counter. Define ALU_RESULT_PARITY_EN to add the out_parity port.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [4:0]               in_opcode,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [4:0]               out_opcode,
  output logic                     out_overflow,
  output logic                     out_is_zero,
  output logic                     out_is_neg,
`ifdef ALU_RESULT_PARITY_EN
  output logic                     out_parity,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ovf_count,
  input  logic                     clr_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] res_mem  [DEPTH];
  logic [4:0]       op_mem   [DEPTH];
  logic             ovf_mem  [DEPTH];
  logic             zero_mem [DEPTH];
  logic             neg_mem  [DEPTH];
`ifdef ALU_RESULT_PARITY_EN
  logic             par_mem  [DEPTH];
`endif

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             full, empty, push, pop;

  // Full/empty come from the registered level only, so in_ready never depends on out_ready.
  assign full  = (level_q == LevelFull);
  assign empty = (level_q == '0);
  assign push  = in_valid && !full;
  assign pop   = !empty && out_ready;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (clr_count) begin
      ovf_count_d = '0;
    end else if (push && in_overflow && (ovf_count_q != CntMax)) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  // Entry storage needs no reset: outputs are masked to zero whenever the buffer is empty.
  always_ff @(posedge clock) begin
    if (resetn && push) begin
      res_mem[wr_ptr_q]  <= in_result;
      op_mem[wr_ptr_q]   <= in_opcode;
      ovf_mem[wr_ptr_q]  <= in_overflow;
      zero_mem[wr_ptr_q] <= (in_result == '0);
      neg_mem[wr_ptr_q]  <= in_result[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
      par_mem[wr_ptr_q]  <= ^in_result;
`endif
    end
  end

  always_comb begin
    out_result   = '0;
    out_opcode   = '0;
    out_overflow = 1'b0;
    out_is_zero  = 1'b0;
    out_is_neg   = 1'b0;
`ifdef ALU_RESULT_PARITY_EN
    out_parity   = 1'b0;
`endif
    if (!empty) begin
      out_result   = res_mem[rd_ptr_q];
      out_opcode   = op_mem[rd_ptr_q];
      out_overflow = ovf_mem[rd_ptr_q];
      out_is_zero  = zero_mem[rd_ptr_q];
      out_is_neg   = neg_mem[rd_ptr_q];
`ifdef ALU_RESULT_PARITY_EN
      out_parity   = par_mem[rd_ptr_q];
`endif
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = level_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (DEPTH=2, CNT_W=2) with hand-computed expectations.
module tb_alu_result_stage;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_opcode;
  logic        in_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_opcode;
  logic        out_overflow, out_is_zero, out_is_neg;
`ifdef ALU_RESULT_PARITY_EN
  logic        out_parity;
`endif
  logic [1:0]  level;
  logic [1:0]  ovf_count;
  logic        clr_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  alu_result_stage #(
    .WIDTH(32),
    .DEPTH(2),
    .CNT_W(2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_opcode   (in_opcode),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_opcode  (out_opcode),
    .out_overflow(out_overflow),
    .out_is_zero (out_is_zero),
    .out_is_neg  (out_is_neg),
`ifdef ALU_RESULT_PARITY_EN
    .out_parity  (out_parity),
`endif
    .level       (level),
    .ovf_count   (ovf_count),
    .clr_count   (clr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled and inputs changed 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b1; in_result = 32'h55; in_opcode = 5'd1;
    in_overflow = 1'b1; out_ready = 1'b0; clr_count = 1'b0;
    #1;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_ovf", 32'(ovf_count), 32'd0);
    check("rst_result", out_result, 32'd0);
    resetn = 1'b1; in_valid = 1'b0; in_overflow = 1'b0;

    // Single pass-through
    in_valid = 1'b1; in_result = 32'hF0F0_0000; in_opcode = 5'd3; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_result", out_result, 32'hF0F0_0000);
    check("pass_opcode", 32'(out_opcode), 32'd3);
    check("pass_zero", 32'(out_is_zero), 32'd0);
    check("pass_neg", 32'(out_is_neg), 32'd1);
    check("pass_level", 32'(level), 32'd1);
    step();
    check("pass_drain", 32'(out_valid), 32'd0);
    check("pass_empty_res", out_result, 32'd0);

    // Fill and backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_opcode = 5'd2; in_result = 32'h1;
    step();
    check("fill1_level", 32'(level), 32'd1);
    check("fill1_ready", 32'(in_ready), 32'd1);
    in_result = 32'h2;
    step();
    check("fill2_level", 32'(level), 32'd2);
    check("fill2_ready", 32'(in_ready), 32'd0);
    in_result = 32'h3;
    step();
    check("full_level", 32'(level), 32'd2);
    check("full_head", out_result, 32'h1);
    check("full_stable", 32'(out_valid), 32'd1);
    // Full with pop: the slot frees but the push is still refused this edge
    out_ready = 1'b1;
    step();
    check("fullpop_level", 32'(level), 32'd1);
    check("fullpop_head", out_result, 32'h2);
    in_valid = 1'b0;
    step();
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Streaming push+pop at level 1; pointers wrap repeatedly
    out_ready = 1'b0; in_valid = 1'b1; in_result = 32'd100;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = 32'(i);
      step();
      check("stream_level", 32'(level), 32'd1);
      check("stream_head", out_result, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_empty", 32'(level), 32'd0);

    // Saturating overflow counter (CNT_W=2 saturates at 3)
    in_valid = 1'b1; in_overflow = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_result = 32'h10 + 32'(k);
      step();
      check("ovf_count", 32'(ovf_count), (k < 3) ? 32'(k + 1) : 32'd3);
      check("ovf_head_flag", 32'(out_overflow), 32'd1);
    end
    clr_count = 1'b1;
    step();
    check("ovf_clr_prio", 32'(ovf_count), 32'd0);
    clr_count = 1'b0;
    step();
    check("ovf_after_clr", 32'(ovf_count), 32'd1);
    in_valid = 1'b0; in_overflow = 1'b0;
    step();
    check("ovf_drain", 32'(level), 32'd0);

    // Zero / negative / parity flags
    out_ready = 1'b0; in_valid = 1'b1; in_result = 32'h0; in_opcode = 5'd7;
    step();
    check("zero_flag", 32'(out_is_zero), 32'd1);
    check("zero_neg", 32'(out_is_neg), 32'd0);
    check("zero_opcode", 32'(out_opcode), 32'd7);
`ifdef ALU_RESULT_PARITY_EN
    check("zero_parity", 32'(out_parity), 32'd0);
`endif
    out_ready = 1'b1; in_result = 32'h7;
    step();
    check("seven_result", out_result, 32'h7);
    check("seven_zero", 32'(out_is_zero), 32'd0);
`ifdef ALU_RESULT_PARITY_EN
    check("seven_parity", 32'(out_parity), 32'd1);
`endif
    in_valid = 1'b0;
    step();
    check("flags_empty_zero", 32'(out_is_zero), 32'd0);

    // Reset mid-operation discards held entries
    out_ready = 1'b0; in_valid = 1'b1; in_result = 32'hAA;
    step(); step();
    check("pre_rst_level", 32'(level), 32'd2);
    resetn = 1'b0;
    step();
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1; in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
